// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment clock display.
// Segment patterns are active-low, bit 0 = segment a through bit 6 = segment g.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;

  localparam logic [IDX_W-1:0] IDX_HOUR_T = 3'd0;
  localparam logic [IDX_W-1:0] IDX_HOUR_U = 3'd1;
  localparam logic [IDX_W-1:0] IDX_MIN_T  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_MIN_U  = 3'd3;
  localparam logic [IDX_W-1:0] IDX_SEC_T  = 3'd4;
  localparam logic [IDX_W-1:0] IDX_SEC_U  = 3'd5;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Full output words with the decimal point in bit 7.
  localparam logic [SEG_W:0]        SEG_OFF = {1'b1, SEG_BLANK};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = 6'h3F;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } time_bcd_t;

  // Decimal point separates HH.MM.SS, so it follows the hour and minute units.
  function automatic logic dp_lit(input logic [IDX_W-1:0] idx);
    return (idx == IDX_HOUR_U) || (idx == IDX_MIN_U);
  endfunction

  function automatic logic [NIB_W-1:0] nibble_sel(input time_bcd_t t,
                                                  input logic [IDX_W-1:0] idx);
    logic [NIB_W-1:0] nib;
    nib = t.sec[3:0];
    case (idx)
      IDX_HOUR_T: nib = t.hour[7:4];
      IDX_HOUR_U: nib = t.hour[3:0];
      IDX_MIN_T:  nib = t.min[7:4];
      IDX_MIN_U:  nib = t.min[3:0];
      IDX_SEC_T:  nib = t.sec[7:4];
      IDX_SEC_U:  nib = t.sec[3:0];
      default:    nib = t.sec[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low seven-segment pattern; non-decimal codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output logic [SEG_W-1:0] pattern_c_o
);

  always_comb begin
    pattern_c_o = SEG_DASH;
    case (nibble_i)
      4'd0:    pattern_c_o = SEG_0;
      4'd1:    pattern_c_o = SEG_1;
      4'd2:    pattern_c_o = SEG_2;
      4'd3:    pattern_c_o = SEG_3;
      4'd4:    pattern_c_o = SEG_4;
      4'd5:    pattern_c_o = SEG_5;
      4'd6:    pattern_c_o = SEG_6;
      4'd7:    pattern_c_o = SEG_7;
      4'd8:    pattern_c_o = SEG_8;
      4'd9:    pattern_c_o = SEG_9;
      default: pattern_c_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Six-digit HH.MM.SS multiplexed display driver with per-slot anti-ghost
// blanking, frame-coherent time snapshot and per-field blinking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 4,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            hour_bcd,
  input  logic [7:0]            min_bcd,
  input  logic [7:0]            sec_bcd,
  input  logic [2:0]            blink_mask,
  output logic [SEG_W:0]        seg,
  output logic [NUM_DIGITS-1:0] dig_sel
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYC);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  time_bcd_t             snap_q, snap_d;
  logic [FRM_W-1:0]      frm_q, frm_d;
  logic                  blink_q, blink_d;
  logic [SEG_W:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic                  slot_tick;
  logic                  frame_tick;
  logic                  field_blink;
  logic [NIB_W-1:0]      cur_nib;
  logic [SEG_W-1:0]      cur_pat;

  assign cur_nib = nibble_sel(snap_q, idx_q);

  seg7_decode u_decode (
    .nibble_i    (cur_nib),
    .pattern_c_o (cur_pat)
  );

  // Scan timing: prescaler, digit index, snapshot on frame wrap, blink phase.
  always_comb begin
    presc_d    = presc_q + PRE_W'(1);
    idx_d      = idx_q;
    snap_d     = snap_q;
    frm_d      = frm_q;
    blink_d    = blink_q;
    slot_tick  = (presc_q == PRE_LAST);
    frame_tick = slot_tick && (idx_q == IDX_LAST);

    if (slot_tick) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (frame_tick) begin
      snap_d = '{hour: hour_bcd, min: min_bcd, sec: sec_bcd};
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end
  end

  // Blink mask is sampled live so a field can start blinking mid-frame.
  always_comb begin
    field_blink = blink_mask[0];
    case (idx_q)
      IDX_HOUR_T, IDX_HOUR_U: field_blink = blink_mask[2];
      IDX_MIN_T,  IDX_MIN_U:  field_blink = blink_mask[1];
      default:                field_blink = blink_mask[0];
    endcase
  end

  always_comb begin
    seg_d = SEG_OFF;
    dig_d = DIG_OFF;
    if (presc_q >= PRE_BLANK) begin
      dig_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!(blink_q && field_blink)) begin
        seg_d = {~dp_lit(idx_q), cur_pat};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      frm_q   <= '0;
      blink_q <= 1'b0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: directed scenarios plus random inputs,
// compared every cycle against a cycle-count based display model.
module tb_seg7_scan;

  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned BLANK_CYC    = 2;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned FRAME        = SCAN_DIV * 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [2:0] blink_mask;
  logic [7:0] seg;
  logic [5:0] dig_sel;

  int checks = 0;
  int errors = 0;

  int unsigned k;
  logic [23:0] snap_cur, snap_pend;
  logic [7:0]  exp_seg;
  logic [5:0]  exp_dig;
  bit          rand_mode;

  logic [7:0] pat_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

  always #5 clk = ~clk;

  seg7_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hour_bcd   (hour_bcd),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .blink_mask (blink_mask),
    .seg        (seg),
    .dig_sel    (dig_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after edge k, from elapsed cycles since reset release.
  task automatic model_edge();
    int unsigned pos   = k % SCAN_DIV;
    int unsigned idx   = (k / SCAN_DIV) % 6;
    int unsigned frame = k / FRAME;
    logic [3:0]  nib;
    if ((k % FRAME == 0) && (k != 0)) snap_cur = snap_pend;
    exp_seg = 8'hFF;
    exp_dig = 6'h3F;
    if (pos >= BLANK_CYC) begin
      for (int d = 0; d < 6; d++) exp_dig[d] = (d != idx);
      nib = snap_cur[23 - 4*idx -: 4];
      if (((frame / BLINK_FRAMES) % 2 == 1) && blink_mask[2 - idx/2]) begin
        exp_seg = 8'hFF;
      end else begin
        exp_seg = pat_tab[nib];
        if (idx == 1 || idx == 3) exp_seg[7] = 1'b0;
      end
    end
    if (k % FRAME == FRAME - 1) snap_pend = {hour_bcd, min_bcd, sec_bcd};
    k++;
  endtask

  function automatic logic [7:0] rand_bcd();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check($sformatf("seg@%0d", k - 1), seg, exp_seg);
    check($sformatf("dig@%0d", k - 1), dig_sel, exp_dig);
    if (rand_mode) begin
      if ($urandom_range(0, 15) == 0) hour_bcd = rand_bcd();
      if ($urandom_range(0, 15) == 0) min_bcd  = rand_bcd();
      if ($urandom_range(0, 15) == 0) sec_bcd  = rand_bcd();
      if ($urandom_range(0, 63) == 0) blink_mask = 3'($urandom_range(0, 7));
    end
  endtask

  // Run until the output produced by edge e has been checked.
  task automatic run_to(input int unsigned e);
    while (k <= e) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    k         = 0;
    snap_cur  = '0;
    snap_pend = '0;
  endtask

  initial begin
    rand_mode  = 1'b0;
    hour_bcd   = 8'h23;
    min_bcd    = 8'h45;
    sec_bcd    = 8'h09;
    blink_mask = 3'b000;
    k          = 0;
    snap_cur   = '0;
    snap_pend  = '0;

    repeat (2) @(negedge clk);
    check("rst_seg", seg, 8'hFF);
    check("rst_dig", dig_sel, 6'h3F);
    release_reset();

    // First frame shows the zero snapshot from slot cycle 3.
    run_to(1);
    check("first_blank_seg", seg, 8'hFF);
    run_to(2);
    check("first_seg", seg, 8'hC0);
    check("first_dig", dig_sel, 6'h3E);

    run_to(FRAME + 2);
    check("f1_idx0_seg", seg, 8'hA4);
    check("f1_idx0_dig", dig_sel, 6'h3E);
    run_to(FRAME + 8 + 2);
    check("f1_idx1_seg", seg, 8'h30);
    check("f1_idx1_dig", dig_sel, 6'h3D);

    // Minute update while idx2 is lit must not reach idx3 until next frame.
    run_to(FRAME + 16 + 2);
    min_bcd = 8'h46;
    run_to(FRAME + 24 + 2);
    check("tear_old_seg", seg, 8'h12);
    run_to(FRAME + 40 + 2);
    check("f1_idx5_seg", seg, 8'h90);
    check("f1_idx5_dig", dig_sel, 6'h1F);
    run_to(2*FRAME + 24 + 2);
    check("tear_new_seg", seg, 8'h02);

    blink_mask = 3'b010;
    run_to(3*FRAME + 2);
    check("blink_hour_seg", seg, 8'hA4);
    run_to(3*FRAME + 16 + 2);
    check("blink_mint_seg", seg, 8'hFF);
    check("blink_mint_dig", dig_sel, 6'h3B);
    run_to(3*FRAME + 24 + 2);
    check("blink_minu_seg", seg, 8'hFF);
    run_to(3*FRAME + 40 + 2);
    check("blink_sec_seg", seg, 8'h90);
    run_to(4*FRAME + 16 + 2);
    check("blink_off_seg", seg, 8'h99);

    sec_bcd = 8'hFA;
    run_to(5*FRAME + 32 + 2);
    check("bad_bcd_idx4", seg, 8'hBF);
    run_to(5*FRAME + 40 + 2);
    check("bad_bcd_idx5", seg, 8'hBF);

    rand_mode = 1'b1;
    run_to(26*FRAME);

    // Reset in the middle of idx3 (prescaler 5), then restart from idx0.
    while (k % FRAME != 29) step();
    rand_mode = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_seg", seg, 8'hFF);
    check("midrst_dig", dig_sel, 6'h3F);
    repeat (2) @(negedge clk);
    check("midrst_hold_dig", dig_sel, 6'h3F);
    release_reset();
    run_to(2);
    check("restart_seg", seg, 8'hC0);
    check("restart_dig", dig_sel, 6'h3E);
    rand_mode = 1'b1;
    run_to(4*FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
